switch_input_buffer: RTL and testbench

- Receiving end of a DySER switch-to-switch link. It accepts the data bundle driven by a neighbouring switch output and holds it in a small FIFO.
- The head entry is presented to the local switch outputs that select this input. An entry retires only after every selecting output has taken it (multicast).
- Each retirement returns one credit upstream, so the sender never overruns the buffer.

---
 rtl/dyser_link_pkg.sv | 20 ++
 rtl/switch_input_fifo.sv | 48 ++++
 rtl/switch_input_buffer.sv | 86 ++++++++
 tb/tb_switch_input_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dyser_link_pkg.sv
// Shared definitions for DySER switch-to-switch links: bundle width, valid bit
// position and a constant clog2 helper for pointer/count sizing.
`ifndef PATH_WIDTH
`define PATH_WIDTH 15
`endif

package dyser_link_pkg;

  localparam int PATH_WIDTH = `PATH_WIDTH;
  localparam int BUNDLE_W   = PATH_WIDTH + 1;
  localparam int VALID_BIT  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/switch_input_fifo.sv
// Storage half of the switch input buffer: circular FIFO with pointers, count
// and full/empty flags. Callers gate wr against full and deq against empty.
module switch_input_fifo
  import dyser_link_pkg::*;
#(
  parameter int W     = BUNDLE_W,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         deq,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  // DEPTH is a power of 2, so pointers wrap for free at PTR_W bits.
  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr) - CNT_W'(deq);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/switch_input_buffer.sv
// Receiving end of a DySER switch link: buffers upstream bundles, multicasts the
// head to selecting outputs, returns one credit per retired entry.
// Optional sticky overflow check: define SWITCH_INPUT_OVERFLOW_CHK_EN.
module switch_input_buffer
  import dyser_link_pkg::*;
#(
  parameter int PW      = PATH_WIDTH,
  parameter int NUM_OUT = 5,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PW:0]        d_in,
  output logic               credit_out,
  input  logic [NUM_OUT-1:0] sel,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [PW:0]        d_out,
  output logic [NUM_OUT-1:0] out_taken,
  output logic               empty,
  output logic               full,
  output logic               ovf_err
);

  // Handshake: the head is offered to every output with sel set; output i takes
  // it in a cycle where it is still pending and out_ready[i] is high. The entry
  // retires when the last pending selector takes it; served remembers earlier takers.
  logic [NUM_OUT-1:0] served;
  logic [NUM_OUT-1:0] pending;
  logic [NUM_OUT-1:0] take;
  logic               wr;
  logic               deq;
  logic               fifo_empty;
  logic               fifo_full;

  assign pending = sel & ~served;
  assign take    = pending & out_ready & {NUM_OUT{~fifo_empty}};
  assign deq     = ~fifo_empty & (|sel) & ((pending & ~out_ready) == '0);
  assign wr      = d_in[VALID_BIT] & (~fifo_full | deq);

  switch_input_fifo #(
    .W     (PW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata (d_in),
    .deq   (deq),
    .rdata (d_out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served     <= '0;
      credit_out <= 1'b0;
    end else begin
      served     <= deq ? '0 : (served | take);
      credit_out <= deq;
    end
  end

  assign out_taken = take;
  assign empty     = fifo_empty;
  assign full      = fifo_full;

`ifdef SWITCH_INPUT_OVERFLOW_CHK_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (d_in[VALID_BIT] & fifo_full & ~deq) ovf_q <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst && d_in[VALID_BIT] && fifo_full && !deq)
      $error("switch_input_buffer: write while full, bundle dropped");
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_buffer.sv
// Directed bench for switch_input_buffer: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_switch_input_buffer;
  import dyser_link_pkg::*;

  localparam int N     = 5;
  localparam int DEPTH = 2;
  localparam int BW    = BUNDLE_W;

`ifdef SWITCH_INPUT_OVERFLOW_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [BW-1:0] d_in;
  logic          credit_out;
  logic [N-1:0]  sel;
  logic [N-1:0]  out_ready;
  logic [BW-1:0] d_out;
  logic [N-1:0]  out_taken;
  logic          empty;
  logic          full;
  logic          ovf_err;

  int n_cmp;
  int n_bad;
  int cred_seen;

  switch_input_buffer #(.NUM_OUT(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .credit_out (credit_out),
    .sel        (sel),
    .out_ready  (out_ready),
    .d_out      (d_out),
    .out_taken  (out_taken),
    .empty      (empty),
    .full       (full),
    .ovf_err    (ovf_err)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: exp_q holds buffered bundles in arrival order
  logic [BW-1:0] exp_q[$];
  logic [N-1:0]  m_served;
  logic          m_credit;
  logic          m_ovf;

  always @(negedge clk) begin
    logic [BW-1:0] e_dout;
    logic [N-1:0]  e_take;
    logic          retire;
    logic          accept;
    if (rst) begin
      exp_q.delete();
      m_served = '0;
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      chk("rst_d_out", 32'(d_out), 32'h0);
      chk("rst_empty", 32'(empty), 32'h1);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_credit", 32'(credit_out), 32'h0);
      chk("rst_ovf", 32'(ovf_err), 32'h0);
    end else begin
      if (credit_out === 1'b1) cred_seen++;
      e_dout = (exp_q.size() > 0) ? exp_q[0] : '0;
      e_take = (exp_q.size() > 0) ? (sel & ~m_served & out_ready) : '0;
      chk("d_out", 32'(d_out), 32'(e_dout));
      chk("out_taken", 32'(out_taken), 32'(e_take));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("credit_out", 32'(credit_out), 32'(m_credit));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      // the head retires once every selector has taken it, now or earlier
      retire = (exp_q.size() > 0) && (sel != '0) && (((m_served | e_take) & sel) == sel);
      accept = d_in[VALID_BIT] && ((exp_q.size() < DEPTH) || retire);
      if (d_in[VALID_BIT] && (exp_q.size() == DEPTH) && !retire && OVF_EXP) m_ovf = 1'b1;
      if (retire) begin
        void'(exp_q.pop_front());
        m_served = '0;
      end else begin
        m_served = m_served | e_take;
      end
      if (accept) exp_q.push_back(d_in);
      m_credit = retire;
    end
  end

  // driver tasks
  task automatic drive(input logic [N-1:0] s, input logic [N-1:0] r, input logic [BW-1:0] d);
    sel       = s;
    out_ready = r;
    d_in      = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [N-1:0] s, input logic [N-1:0] r, input logic [BW-1:0] d);
    drive(s, r, d);
    tick();
  endtask

  int c0;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cred_seen = 0;
    rst = 1'b1;
    drive('0, '0, '0);
    tick();
    tick();
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) step('0, '0, '0);
    chk("idle_empty", 32'(empty), 32'h1);
    chk("idle_d_out", 32'(d_out), 32'h0);

    // single-cast streaming
    c0 = cred_seen;
    step(5'b00001, 5'b00001, 16'h00A2);
    chk("sc_head_a2", 32'(d_out), 32'h00A2);
    chk("sc_cred0", 32'(credit_out), 32'h0);
    drive(5'b00001, 5'b00001, 16'h00B2);
    #1 chk("sc_take_a2", 32'(out_taken), 32'h01);
    tick();
    chk("sc_head_b2", 32'(d_out), 32'h00B2);
    chk("sc_cred1", 32'(credit_out), 32'h1);
    step(5'b00001, 5'b00001, '0);
    chk("sc_empty", 32'(empty), 32'h1);
    chk("sc_cred2", 32'(credit_out), 32'h1);
    step('0, '0, '0);
    chk("sc_credits", 32'(cred_seen - c0), 32'd2);

    // staggered multicast
    c0 = cred_seen;
    step(5'b10011, 5'b00000, 16'h00C2);
    drive(5'b10011, 5'b00001, '0);
    #1 chk("mc_take0", 32'(out_taken), 32'h01);
    tick();
    chk("mc_hold1", 32'(d_out), 32'h00C2);
    chk("mc_nocred1", 32'(credit_out), 32'h0);
    drive(5'b10011, 5'b00010, '0);
    #1 chk("mc_take1", 32'(out_taken), 32'h02);
    tick();
    chk("mc_hold2", 32'(d_out), 32'h00C2);
    drive(5'b10011, 5'b10000, '0);
    #1 chk("mc_take2", 32'(out_taken), 32'h10);
    tick();
    chk("mc_empty", 32'(empty), 32'h1);
    step(5'b10011, 5'b00000, '0);
    chk("mc_credits", 32'(cred_seen - c0), 32'd1);

    // fill, back-pressure, then full with simultaneous write and deq
    c0 = cred_seen;
    step(5'b00001, 5'b00000, 16'h00D2);
    step(5'b00001, 5'b00000, 16'h00E2);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_head", 32'(d_out), 32'h00D2);
    step(5'b00001, 5'b00001, 16'h00F2);
    chk("wd_full", 32'(full), 32'h1);
    chk("wd_head", 32'(d_out), 32'h00E2);
    step(5'b00001, 5'b00001, '0);
    chk("wd_head_f2", 32'(d_out), 32'h00F2);
    chk("wd_notfull", 32'(full), 32'h0);
    step(5'b00001, 5'b00001, '0);
    chk("wd_empty", 32'(empty), 32'h1);
    step(5'b00001, 5'b00000, '0);
    chk("wd_credits", 32'(cred_seen - c0), 32'd3);

    // overflow: write while full without deq is dropped
    step(5'b00001, 5'b00000, 16'h1162);
    step(5'b00001, 5'b00000, 16'h2262);
    step(5'b00001, 5'b00000, 16'h3362);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_head", 32'(d_out), 32'h1162);
    chk("ovf_flag", 32'(ovf_err), 32'(OVF_EXP));
    step(5'b00001, 5'b00001, '0);
    chk("ovf_second", 32'(d_out), 32'h2262);
    step(5'b00001, 5'b00001, '0);
    chk("ovf_dropped", 32'(empty), 32'h1);

    // sel==0 holds the head with no credit
    step(5'b00000, 5'b11111, 16'h4462);
    step(5'b00000, 5'b11111, '0);
    c0 = cred_seen;
    for (int i = 0; i < 20; i++) step(5'b00000, 5'b11111, '0);
    chk("hold_head", 32'(d_out), 32'h4462);
    chk("hold_nocred", 32'(cred_seen - c0), 32'd0);
    step(5'b00100, 5'b00100, '0);
    chk("hold_drain", 32'(empty), 32'h1);

    // reset mid-multicast discards everything, no credit
    step(5'b00011, 5'b00000, 16'h5562);
    step(5'b00011, 5'b00001, '0);
    rst = 1'b1;
    #1;
    chk("rmid_empty", 32'(empty), 32'h1);
    chk("rmid_d_out", 32'(d_out), 32'h0);
    tick();
    rst = 1'b0;
    step('0, '0, '0);
    chk("rmid_cred", 32'(credit_out), 32'h0);
    step('0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
